ecp5pll_phase_ctrl: RTL and testbench
=====================================

Name: ecp5pll_phase_ctrl

Overview:
Dynamic phase-shift sequencer that drives the ECP5 PLL wrapper's phasesel/phasedir/phasestep/phaseloadreg inputs. It accepts "shift channel N by K steps" or "reload static phase" commands over a valid/ready handshake. It generates correctly spaced setup, pulse and gap timing, and tracks the accumulated step offset per output. It sits between the fabric (e.g. a DDR/video calibration loop) and the PLL; each step is 1/8 VCO period.

Parameters:
SETUP_CYC, 4, cycles phasesel/phasedir held stable before the first pulse (>=1)
PULSE_CYC, 4, cycles phasestep/phaseloadreg held high per pulse (>=1)
GAP_CYC, 8, low cycles after each pulse before the next pulse or done (>=1)
STEP_W, 8, width of step-count request field
POS_W, 10, width of each per-channel signed step accumulator

Ports:
clk_i  in  1  PLL-domain fabric clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&&ready
req_sel  in  2  output index: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3 (logical numbering, as the PLL wrapper's phasesel expects)
req_dir  in  1  passed to phasedir; 0 = +1 per step, 1 = -1 per step in accumulator
req_steps  in  STEP_W  number of phasestep pulses
req_load  in  1  1 = single phaseloadreg pulse instead of steps (req_steps, req_dir ignored)
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle abort pulse (always 0 without feature)
locked  in  1  PLL lock
phasesel  out  2  to PLL
phasedir  out  1  to PLL
phasestep  out  1  to PLL
phaseloadreg  out  1  to PLL
pos  out  4*POS_W  per-channel accumulator; channel n at [n*POS_W +: POS_W], two's complement

Behaviour:
- Reset (reset_n=0 at clk_i edge): all outputs 0, pos all 0, state IDLE. Takes effect at the next edge, including mid-sequence: phasestep/phaseloadreg drop and no done is issued.
- States: IDLE, SETUP, PULSE, GAP. A single down-counter is reloaded on each state entry.
- IDLE: req_ready=1. On accept, register phasesel<=req_sel and phasedir<=req_dir (phasedir unchanged if req_load), latch remaining<=req_steps and load flag.
  - req_steps=0 and !req_load: stay in IDLE, done=1 the next cycle, no pulses.
  - Otherwise go to SETUP; busy=1.
- SETUP: SETUP_CYC cycles, pulses low, then PULSE.
- PULSE: PULSE_CYC cycles with phasestep=1 (or phaseloadreg=1 if load).
  - On the last PULSE cycle's edge: remaining decrements.
  - pos[sel] updates: +1 (dir=0) or -1 (dir=1), wraps mod 2^POS_W. If load, pos[sel] is cleared to 0.
- GAP: GAP_CYC cycles low. Then go to PULSE if remaining>0, else IDLE.
- done=1 and busy=0 in the first IDLE cycle. req_ready is also 1 that cycle, so back-to-back accepts are legal.
- Accept-to-done latency: SETUP_CYC + N*(PULSE_CYC+GAP_CYC) cycles; load counts as N=1.
- phasesel/phasedir are stable from the cycle after accept until the next accept; they never change while busy.
- phasestep and phaseloadreg are never high together. All PLL-side outputs are registered (glitch-free).
- req_* are sampled only on accept; changes while busy are ignored.

Optional Feature:
ECP5PLL_PHASE_LOCK_GUARD_EN.
- Defined:
  - req_ready = IDLE && locked.
  - If locked falls while busy: at the next edge, pulses go low, state goes to IDLE, err=1 for one cycle, no done.
  - pos keeps the steps already applied.
- Undefined: locked is ignored and err is tied 0.

Decomposition:
- Package ecp5pll_phase_pkg: state enum (IDLE, SETUP, PULSE, GAP), channel index constants CH_CLKOP..CH_CLKOS3, and a function returning the PULSE_CYC+GAP_CYC step period.
- One sub-module, ecp5pll_phase_timer: loadable down-counter with a done flag, width derived from max(SETUP_CYC,PULSE_CYC,GAP_CYC).

Test Plan:
- Reset with reset_n=0 for 3 cycles -> all outputs 0, pos=0, req_ready=1.
- sel=2, dir=0, steps=3 with defaults:
  - phasesel=2 from accept+1.
  - 3 phasestep pulses, each 4 high and 8 low, the first rising at accept+5.
  - done at accept+40; pos[2]=3.
- sel=1, dir=1, steps=1 from pos 0 -> pos[1]=10'h3FF (-1), done at accept+16.
- Load on sel=3 with pos[3]=5 -> a 4-cycle phaseloadreg pulse, phasestep stays 0, pos[3]=0, done at accept+16.
- steps=0 -> done at accept+1, no pulses; a second request held valid is accepted in the done cycle.
- reset_n=0 during the 2nd PULSE -> phasestep=0 next edge, busy=0, no done.
- With the macro: locked=0 -> req_ready=0; locked dropping in GAP -> err pulse, pos reflects completed steps only.

Source files
------------

// File: rtl/ecp5pll_phase_pkg.sv
// rtl/ecp5pll_phase_pkg.sv - shared types and constants for the ECP5 PLL dynamic phase sequencer
package ecp5pll_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } phase_state_e;

  // Logical output numbering as the PLL wrapper's phasesel expects
  localparam logic [1:0] CH_CLKOP  = 2'd0;
  localparam logic [1:0] CH_CLKOS  = 2'd1;
  localparam logic [1:0] CH_CLKOS2 = 2'd2;
  localparam logic [1:0] CH_CLKOS3 = 2'd3;

  function automatic int unsigned step_period(input int unsigned pulse_cyc,
                                              input int unsigned gap_cyc);
    return pulse_cyc + gap_cyc;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_timer.sv
// rtl/ecp5pll_phase_timer.sv - loadable down-counter timing each sequencer state
module ecp5pll_phase_timer #(
  parameter int unsigned MAX_CYC = 8,
  parameter int unsigned CNT_W   = $clog2(MAX_CYC + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;

  // Loading N makes expired_o rise in the Nth cycle after the load edge
  assign expired_o = (count_q <= CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// rtl/ecp5pll_phase_ctrl.sv - ECP5 PLL phasesel/phasedir/phasestep/phaseloadreg sequencer
// Optional lock guard (abort on lost lock, err pulse) enabled by ECP5PLL_PHASE_LOCK_GUARD_EN.
module ecp5pll_phase_ctrl
  import ecp5pll_phase_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned POS_W     = 10
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [STEP_W-1:0]  req_steps,
  input  logic               req_load,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               locked,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg,
  output logic [4*POS_W-1:0] pos
);

  localparam int unsigned TMR_MAX =
    (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                            : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int unsigned CNT_W = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD    = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] GAP_LD      = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] GAP_LAST_LD = CNT_W'(GAP_CYC - 1);

  phase_state_e      state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              load_q, load_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              ldreg_q, ldreg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [POS_W-1:0]  pos_q [4];
  logic [POS_W-1:0]  pos_d [4];

  logic              accept;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_exp;

  ecp5pll_phase_timer #(
    .MAX_CYC (TMR_MAX),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

`ifdef ECP5PLL_PHASE_LOCK_GUARD_EN
  assign req_ready = (state_q == ST_IDLE) && locked;
`else
  logic unused_locked;
  assign unused_locked = locked;
  assign req_ready     = (state_q == ST_IDLE);
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load_d      = load_q;
    sel_d       = sel_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = SETUP_LD;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sel_d       = req_sel;
          remaining_d = req_steps;
          load_d      = req_load;
          if (!req_load) dir_d = req_dir;
          if (!req_load && (req_steps == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end
        end
      end

      ST_SETUP: begin
        if (tmr_exp) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end

      ST_PULSE: begin
        if (tmr_exp) begin
          if (load_q)     pos_d[sel_q] = '0;
          else if (dir_q) pos_d[sel_q] = pos_q[sel_q] - POS_W'(1);
          else            pos_d[sel_q] = pos_q[sel_q] + POS_W'(1);
          // Final gap is one short: the done cycle is its last low cycle
          if (load_q || (remaining_q == STEP_W'(1))) begin
            remaining_d = '0;
            if (GAP_CYC > 1) begin
              state_d  = ST_GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_LAST_LD;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            remaining_d = remaining_q - STEP_W'(1);
            state_d     = ST_GAP;
            tmr_load    = 1'b1;
            tmr_val     = GAP_LD;
          end
        end
      end

      ST_GAP: begin
        if (tmr_exp) begin
          if (remaining_q != '0) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef ECP5PLL_PHASE_LOCK_GUARD_EN
    if ((state_q != ST_IDLE) && !locked) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      pos_d       = pos_q;
      done_d      = 1'b0;
      err_d       = 1'b1;
      tmr_load    = 1'b0;
    end
`endif

    step_d  = (state_d == ST_PULSE) && !load_d;
    ldreg_d = (state_d == ST_PULSE) && load_d;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      load_q      <= 1'b0;
      sel_q       <= 2'd0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      ldreg_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      load_q      <= load_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      ldreg_q     <= ldreg_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pos_q       <= pos_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = ldreg_q;

  for (genvar n = 0; n < 4; n++) begin : g_pos
    assign pos[n*POS_W +: POS_W] = pos_q[n];
  end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// tb/tb_ecp5pll_phase_ctrl.sv - self-checking bench for ecp5pll_phase_ctrl against a timing/position model
module tb_ecp5pll_phase_ctrl;

  localparam int S  = 4;
  localparam int P  = 4;
  localparam int G  = 8;
  localparam int T  = P + G;
  localparam int SW = 8;
  localparam int PW = 10;

  logic            clk_i     = 1'b0;
  logic            reset_n   = 1'b0;
  logic            req_valid = 1'b0;
  logic [1:0]      req_sel   = 2'd0;
  logic            req_dir   = 1'b0;
  logic [SW-1:0]   req_steps = '0;
  logic            req_load  = 1'b0;
  logic            locked    = 1'b1;
  logic            req_ready, busy, done, err;
  logic [1:0]      phasesel;
  logic            phasedir, phasestep, phaseloadreg;
  logic [4*PW-1:0] pos;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] model_pos [4];
  logic          model_dir;

  ecp5pll_phase_ctrl #(
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .GAP_CYC   (G),
    .STEP_W    (SW),
    .POS_W     (PW)
  ) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .req_load     (req_load),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .locked       (locked),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .pos          (pos)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [4*PW-1:0] pack_model();
    logic [4*PW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*PW +: PW] = model_pos[i];
    return v;
  endfunction

  // Cycle r after the accept cycle lies inside one of the n pulses
  function automatic bit in_pulse(input int r, input int n);
    int k;
    if (r <= S) return 1'b0;
    k = (r - S - 1) / T;
    return (k < n) && (((r - S - 1) % T) < P);
  endfunction

  // Called just after the accept edge; watches waveform until past done
  task automatic check_seq(input logic [1:0] sel, input logic dir, input logic ld,
                           input int n, input string name);
    int done_at, bad_wave, bad_done, bad_busy, bad_sel, bad_err, first_bad;
    logic e_pulse;
    done_at  = (n == 0) ? 1 : S + n * T;
    bad_wave = 0; bad_done = 0; bad_busy = 0; bad_sel = 0; bad_err = 0; first_bad = -1;
    for (int r = 1; r <= done_at + 3; r++) begin
      @(negedge clk_i);
      if (r == 1) req_valid = 1'b0;
      e_pulse = in_pulse(r, n);
      if ((phasestep !== (e_pulse && !ld)) || (phaseloadreg !== (e_pulse && ld))) begin
        bad_wave++;
        if (first_bad < 0) first_bad = r;
      end
      if (done !== (r == done_at)) bad_done++;
      if (busy !== ((n > 0) && (r < done_at))) bad_busy++;
      if ((phasesel !== sel) || (phasedir !== dir)) bad_sel++;
      if (err !== 1'b0) bad_err++;
    end
    n_checks++;
    if (bad_wave != 0) begin
      n_fail++;
      $display("FAIL %s pulse_wave: %0d bad cycles (first at accept+%0d), required 0", name, bad_wave, first_bad);
    end
    n_checks++;
    if (bad_done != 0) begin
      n_fail++;
      $display("FAIL %s done_timing: %0d bad cycles, required done only at accept+%0d", name, bad_done, done_at);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL %s busy: %0d bad cycles, required 0", name, bad_busy);
    end
    n_checks++;
    if (bad_sel != 0) begin
      n_fail++;
      $display("FAIL %s sel_dir: %0d bad cycles, required sel=%0d dir=%0d", name, bad_sel, sel, dir);
    end
    n_checks++;
    if (bad_err != 0) begin
      n_fail++;
      $display("FAIL %s err: %0d cycles high, required 0", name, bad_err);
    end
  endtask

  task automatic update_model(input logic [1:0] sel, input logic dir, input logic ld, input int n);
    if (ld) model_pos[sel] = '0;
    else if (dir) model_pos[sel] = model_pos[sel] - PW'(n);
    else model_pos[sel] = model_pos[sel] + PW'(n);
  endtask

  task automatic check_pos(input string name);
    n_checks++;
    if (pos !== pack_model()) begin
      n_fail++;
      $display("FAIL %s pos: got %h, required %h", name, pos, pack_model());
    end
  endtask

  task automatic run_cmd(input logic [1:0] sel, input logic dir, input logic [SW-1:0] steps,
                         input logic ld, input string name);
    int n;
    @(negedge clk_i);
    req_sel = sel; req_dir = dir; req_steps = steps; req_load = ld; req_valid = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b, required 1", name, req_ready);
    end
    @(posedge clk_i);
    n = ld ? 1 : int'(steps);
    if (!ld) model_dir = dir;
    check_seq(sel, model_dir, ld, n, name);
    update_model(sel, dir, ld, n);
    check_pos(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({busy, done, err, phasesel, phasedir, phasestep, phaseloadreg} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset outputs: got %b, required 00000000",
               {busy, done, err, phasesel, phasedir, phasestep, phaseloadreg});
    end
    n_checks++;
    if (pos !== '0) begin
      n_fail++;
      $display("FAIL reset pos: got %h, required 0", pos);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset ready: got %b, required 1", req_ready);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) model_pos[i] = '0;
    model_dir = 1'b0;
  endtask

  task automatic test_steps_up();
    run_cmd(2'd2, 1'b0, 8'd3, 1'b0, "up3_sel2");
  endtask

  task automatic test_step_down();
    run_cmd(2'd1, 1'b1, 8'd1, 1'b0, "down1_sel1");
    n_checks++;
    if (pos[1*PW +: PW] !== 10'h3FF) begin
      n_fail++;
      $display("FAIL down1 pos1: got %h, required 3ff", pos[1*PW +: PW]);
    end
  endtask

  task automatic test_load();
    run_cmd(2'd3, 1'b0, 8'd5, 1'b0, "pre5_sel3");
    run_cmd(2'd3, 1'b1, 8'd7, 1'b1, "load_sel3");
    n_checks++;
    if (pos[3*PW +: PW] !== '0) begin
      n_fail++;
      $display("FAIL load pos3: got %h, required 0", pos[3*PW +: PW]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0; req_load = 1'b0; req_valid = 1'b1;
    @(posedge clk_i);
    model_dir = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({done, busy, req_ready, phasestep} !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b zero_step: done/busy/ready/step got %b, required 1010",
               {done, busy, req_ready, phasestep});
    end
    req_steps = 8'd2;
    @(posedge clk_i);
    check_seq(2'd0, 1'b0, 1'b0, 2, "b2b_second");
    update_model(2'd0, 1'b0, 1'b0, 2);
    check_pos("b2b_second");
  endtask

  task automatic test_random();
    logic [1:0] sel;
    logic dir, ld;
    logic [SW-1:0] steps;
    for (int i = 0; i < 10; i++) begin
      sel   = 2'($urandom_range(0, 3));
      dir   = 1'($urandom_range(0, 1));
      steps = SW'($urandom_range(0, 6));
      ld    = ($urandom_range(0, 4) == 0);
      run_cmd(sel, dir, steps, ld, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge clk_i);
    req_sel = 2'd0; req_dir = 1'b1; req_steps = 8'd3; req_load = 1'b0; req_valid = 1'b1;
    @(posedge clk_i);
    for (int r = 1; r <= S + T + 2; r++) begin
      @(negedge clk_i);
      if (r == 1) req_valid = 1'b0;
    end
    n_checks++;
    if (phasestep !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid in_pulse2: phasestep got %b, required 1", phasestep);
    end
    reset_n = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({phasestep, phaseloadreg, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid outputs: step/ld/busy/done got %b, required 0000",
               {phasestep, phaseloadreg, busy, done});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) model_pos[i] = '0;
    model_dir = 1'b0;
    check_pos("rstmid");
    done_seen = 0;
    for (int r = 0; r < 50; r++) begin
      @(negedge clk_i);
      if (done === 1'b1 || phasestep === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL rstmid no_done: %0d cycles with done/step, required 0", done_seen);
    end
  endtask

`ifdef ECP5PLL_PHASE_LOCK_GUARD_EN
  task automatic test_lock_guard();
    int stray;
    @(negedge clk_i);
    locked = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL guard ready_unlocked: got %b, required 0", req_ready);
    end
    locked = 1'b1;
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd3; req_load = 1'b0; req_valid = 1'b1;
    @(posedge clk_i);
    for (int r = 1; r <= S + P + 2; r++) begin
      @(negedge clk_i);
      if (r == 1) req_valid = 1'b0;
    end
    locked = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({err, busy, phasestep, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL guard abort: err/busy/step/done got %b, required 1000",
               {err, busy, phasestep, done});
    end
    locked = 1'b1;
    model_dir = 1'b0;
    update_model(2'd0, 1'b0, 1'b0, 1);
    check_pos("guard");
    stray = 0;
    for (int r = 0; r < 20; r++) begin
      @(negedge clk_i);
      if (done === 1'b1 || err === 1'b1) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL guard stray_pulse: %0d cycles, required 0", stray);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_steps_up();
    test_step_down();
    test_load();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef ECP5PLL_PHASE_LOCK_GUARD_EN
    test_lock_guard();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
